uart_frame_parser: RTL and testbench

Packet assembler between the UART receiver and the speed calculator. Consumes the per-byte strobe from the receiver, assembles 4-byte frames (id, x, y, 0xFF terminator), validates them and presents one complete (id, x, y) record per frame to the speed stage over a valid/ready handshake. Malformed frames are discarded with an error pulse, and the parser resynchronises on the next 0xFF.

---
 rtl/uart_frame_parser_if.sv | 14 +
 rtl/uart_frame_parser.sv | 169 ++++++++++++++++
 tb/tb_uart_frame_parser.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Record handshake between the frame parser and the speed stage.
interface uart_frame_parser_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 6
);
  logic [DEPTH-1:0] o_id;
  logic [WIDTH-1:0] o_x;
  logic [WIDTH-1:0] o_y;
  logic             o_valid;
  logic             i_ready;

  modport master (output o_id, o_x, o_y, o_valid, input i_ready);
  modport slave  (input o_id, o_x, o_y, o_valid, output i_ready);
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles (id, x, y, 0xFF) byte frames from the UART receiver, validates them
// and presents one record per frame over valid/ready; bad frames pulse o_err.
module uart_frame_parser #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  uart_frame_parser_if.master  rec,
  output logic                 o_err,
  output logic [1:0]           o_err_code,
  output logic [7:0]           o_drop_cnt
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] TERM = '1;
  localparam logic [1:0] ERR_SHORT = 2'd0;
  localparam logic [1:0] ERR_ID    = 2'd1;
  localparam logic [1:0] ERR_TERM  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  typedef enum logic [2:0] {S_ID, S_X, S_Y, S_END, S_RESYNC} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  id_q, id_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              valid_q, valid_d;
  logic [DEPTH-1:0]  out_id_q, out_id_d;
  logic [WIDTH-1:0]  out_x_q, out_x_d, out_y_q, out_y_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic is_term_c, id_oor_c, tmo_hit_c, frame_done_c;

  assign is_term_c = (i_rx_data == TERM);
  assign id_oor_c  = |(i_rx_data >> DEPTH);
  assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ID;
      cnt_q      <= '0;
      id_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      valid_q    <= 1'b0;
      out_id_q   <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      valid_q    <= valid_d;
      out_id_q   <= out_id_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Frame FSM and inter-byte timeout
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    id_d         = id_q;
    x_d          = x_q;
    y_d          = y_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    frame_done_c = 1'b0;
    if (i_rx_valid || state_q == S_ID || state_q == S_RESYNC) cnt_d = '0;

    case (state_q)
      S_ID: begin
        if (i_rx_valid && !is_term_c) begin
          if (id_oor_c) begin
            err_d      = 1'b1;
            err_code_d = ERR_ID;
            state_d    = S_RESYNC;
          end else begin
            id_d    = i_rx_data[DEPTH-1:0];
            state_d = S_X;
          end
        end
      end
      S_X, S_Y: begin
        if (i_rx_valid) begin
          if (is_term_c) begin
            err_d      = 1'b1;
            err_code_d = ERR_SHORT;
            state_d    = S_ID;
          end else if (state_q == S_X) begin
            x_d     = i_rx_data;
            state_d = S_Y;
          end else begin
            y_d     = i_rx_data;
            state_d = S_END;
          end
        end else if (tmo_hit_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = S_ID;
          cnt_d      = '0;
        end
      end
      S_END: begin
        if (i_rx_valid) begin
          if (is_term_c) begin
            frame_done_c = 1'b1;
            state_d      = S_ID;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_TERM;
            state_d    = S_RESYNC;
          end
        end else if (tmo_hit_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = S_ID;
          cnt_d      = '0;
        end
      end
      S_RESYNC: begin
        if (i_rx_valid && is_term_c) state_d = S_ID;
      end
      default: state_d = S_ID;
    endcase
  end

  // Output record: a completed frame is dropped only while a held record is stalled
  always_comb begin
    valid_d    = valid_q;
    out_id_d   = out_id_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    drop_cnt_d = drop_cnt_q;
    if (valid_q && rec.i_ready) valid_d = 1'b0;
    if (frame_done_c) begin
      if (!valid_q || rec.i_ready) begin
        valid_d  = 1'b1;
        out_id_d = id_q;
        out_x_d  = x_q;
        out_y_d  = y_q;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  assign rec.o_id    = out_id_q;
  assign rec.o_x     = out_x_q;
  assign rec.o_y     = out_y_q;
  assign rec.o_valid = valid_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected records and error codes are
// queued as stimulus is driven and retired as the DUT presents them.
module tb_uart_frame_parser;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 6;
  localparam int unsigned TIMEOUT = 4000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       drop_cnt;

  uart_frame_parser_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rec_if ();

  uart_frame_parser #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .rec        (rec_if.master),
    .o_err      (err),
    .o_err_code (err_code),
    .o_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_rec_q[$];
  int exp_err_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pack(input int id, input int x, input int y);
    return (id << 16) | (x << 8) | y;
  endfunction

  // Retire outputs at the negedge before the edge that consumes them
  always @(negedge clk) begin
    if (!rst) begin
      if (rec_if.o_valid && rec_if.i_ready) begin
        if (exp_rec_q.size() == 0) check("unexpected_record",
          pack(int'(rec_if.o_id), int'(rec_if.o_x), int'(rec_if.o_y)), -1);
        else check("record", pack(int'(rec_if.o_id), int'(rec_if.o_x), int'(rec_if.o_y)),
                   exp_rec_q.pop_front());
      end
      if (err) begin
        if (exp_err_q.size() == 0) check("unexpected_err", int'(err_code), -1);
        else check("err_code", int'(err_code), exp_err_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int id, input int x, input int y, input bit expect_out);
    if (expect_out) exp_rec_q.push_back(pack(id, x, y));
    send_byte(8'(id));
    send_byte(8'(x));
    send_byte(8'(y));
    send_byte(8'hFF);
  endtask

  initial begin
    rec_if.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(rec_if.o_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_id", int'(rec_if.o_id), 0);
    rst = 1'b0;

    // Basic frame with one-cycle valid
    send_frame(18, 10, 240, 1'b1);
    check("t1_valid_lat", int'(rec_if.o_valid), 1);
    @(posedge clk); #1;
    check("t1_valid_clr", int'(rec_if.o_valid), 0);

    // Back-pressure: second frame dropped, first held
    rec_if.i_ready = 1'b0;
    send_frame(10, 100, 200, 1'b1);
    send_frame(18, 100, 215, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_drop_cnt", int'(drop_cnt), 1);
    check("t2_held", pack(int'(rec_if.o_id), int'(rec_if.o_x), int'(rec_if.o_y)),
          pack(10, 100, 200));
    check("t2_err_none", int'(err), 0);
    rec_if.i_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_valid_clr", int'(rec_if.o_valid), 0);

    // Out-of-range id then resync
    exp_err_q.push_back(1);
    send_byte(8'd64); send_byte(8'd5); send_byte(8'd6); send_byte(8'hFF);
    send_frame(3, 4, 5, 1'b1);

    // Short frame
    exp_err_q.push_back(0);
    send_byte(8'd7); send_byte(8'd8); send_byte(8'hFF);
    send_frame(1, 2, 3, 1'b1);

    // Missing terminator
    exp_err_q.push_back(2);
    send_byte(8'd7); send_byte(8'd8); send_byte(8'd9); send_byte(8'h20);
    send_byte(8'hFF);
    send_frame(33, 44, 55, 1'b1);

    // Timeout exactly TIMEOUT cycles after the last strobe
    exp_err_q.push_back(3);
    send_byte(8'd7);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("t6_tmo_early", int'(err), 0);
    @(posedge clk); #1;
    check("t6_tmo_err", int'(err), 1);
    check("t6_tmo_code", int'(err_code), 3);
    @(posedge clk); #1;
    check("t6_tmo_pulse", int'(err), 0);
    send_frame(60, 61, 62, 1'b1);

    // Reset mid-frame abandons silently
    send_byte(8'd7); send_byte(8'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t7_rst_valid", int'(rec_if.o_valid), 0);
    send_frame(63, 0, 254, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    check("rec_q_empty", exp_rec_q.size(), 0);
    check("err_q_empty", exp_err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
